// File: rtl/apb_xbee_rx.sv
// apb_xbee_rx: APB3 read-side peripheral for the XBee radio UART.
// Serial bytes are received 8N1, LSB first, and buffered in a byte FIFO.
// Software pops them through the DATA register.
// Optional feature: define RX_TIMEOUT_EN to enable the link_lost radio-silence timer.
module apb_xbee_rx #(
  parameter int unsigned CLK_HZ         = 100000000,
  parameter int unsigned BAUD           = 9600,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic        XBEE_RX,
  output logic        RX_IRQ,
  output logic        link_lost
);

  localparam int unsigned DIV   = CLK_HZ / BAUD;
  localparam int unsigned HALF  = DIV / 2;
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = AW + 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} rx_state_e;

  rx_state_e        state_q, state_d;
  logic [1:0]       sync_q;
  logic             rx_s;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q;
  logic [7:0]       shreg_q;
  logic             armed_q;
  logic             half_hit, bit_hit;
  logic             rx_push, rx_ferr;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          empty, full;
  logic          access, pop, w1c, fifo_we, ovf_set;
  logic          ovf_q, ferr_q;
  logic [7:0]    count8;

  assign rx_s     = sync_q[1];
  assign half_hit = (cnt_q == CNT_W'(HALF - 1));
  assign bit_hit  = (cnt_q == CNT_W'(DIV - 1));

  // Two-flop synchronizer; resets to the idle-high line level
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], XBEE_RX};
  end

  // RX FSM state register
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // RX FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (armed_q && !rx_s) state_d = StStart;
      StStart: if (half_hit) state_d = rx_s ? StIdle : StData;
      StData:  if (bit_hit && (idx_q == 3'd7)) state_d = StStop;
      StStop:  if (bit_hit) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // RX FSM outputs: byte complete with good stop bit, or framing error
  always_comb begin
    rx_push = 1'b0;
    rx_ferr = 1'b0;
    if (state_q == StStop && bit_hit) begin
      rx_push = rx_s;
      rx_ferr = !rx_s;
    end
  end

  // Baud counter, bit index, shift register and re-arm flag.
  // armed_q requires a high line in idle so a held break cannot retrigger.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      armed_q <= 1'b0;
    end else begin
      armed_q <= (state_q == StIdle) && (armed_q || rx_s);
      case (state_q)
        StStart: begin
          cnt_q <= half_hit ? '0 : cnt_q + 1'b1;
          idx_q <= '0;
        end
        StData: begin
          if (bit_hit) begin
            cnt_q          <= '0;
            shreg_q[idx_q] <= rx_s;
            idx_q          <= idx_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StStop:  cnt_q <= bit_hit ? '0 : cnt_q + 1'b1;
        default: cnt_q <= '0;
      endcase
    end
  end

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign access  = PSEL && PENABLE;
  assign pop     = access && !PWRITE && (PADDR[3:2] == 2'd0) && !empty;
  assign w1c     = access && PWRITE && (PADDR[3:2] == 2'd1);
  // A pop frees the slot in the same cycle, so a push into a full FIFO still lands
  assign fifo_we = rx_push && (!full || pop);
  assign ovf_set = rx_push && full && !pop;

  // FIFO storage (no reset needed; count gates visibility)
  always_ff @(posedge PCLK) begin
    if (fifo_we) mem_q[wr_ptr_q] <= shreg_q;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (fifo_we) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({fifo_we, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky error flags; a set in the same cycle as a W1C wins
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      ovf_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_set || (ovf_q && !(w1c && PWDATA[2]));
      ferr_q <= rx_ferr || (ferr_q && !(w1c && PWDATA[3]));
    end
  end

`ifdef RX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_q;
  logic          lost_q;

  // Silence timer: saturates at TIMEOUT_CYCLES; one more idle cycle flags the loss
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      tmo_q  <= '0;
      lost_q <= 1'b0;
    end else if (rx_push) begin
      tmo_q  <= '0;
      lost_q <= 1'b0;
    end else if (tmo_q == TW'(TIMEOUT_CYCLES)) begin
      lost_q <= 1'b1;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  assign link_lost = lost_q;
`else
  localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
  assign link_lost = 1'b0;
`endif

  assign count8  = 8'(count_q);
  assign RX_IRQ  = !empty;
  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;

  // Read mux, decoded from PADDR[3:2] only
  always_comb begin
    PRDATA = '0;
    case (PADDR[3:2])
      2'd0: begin
        if (empty) PRDATA[8] = 1'b1;
        else       PRDATA[7:0] = mem_q[rd_ptr_q];
      end
      2'd1: begin
        PRDATA[0]    = !empty;
        PRDATA[1]    = full;
        PRDATA[2]    = ovf_q;
        PRDATA[3]    = ferr_q;
        PRDATA[4]    = link_lost;
        PRDATA[15:8] = count8;
      end
      default: PRDATA = '0;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{PADDR[31:4], PADDR[1:0], PWDATA[31:4], PWDATA[1:0]};

endmodule

// File: tb/tb_apb_xbee_rx.sv
// Directed bench for apb_xbee_rx: DIV=10, FIFO_DEPTH=4, TIMEOUT_CYCLES=500.
module tb_apb_xbee_rx;

  localparam int unsigned DIV = 10;
`ifdef RX_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        PCLK, PRESERN, PSEL, PENABLE, PWRITE, XBEE_RX;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR, RX_IRQ, link_lost;

  int n_tests = 0;
  int n_fail  = 0;

  logic        irq_pre;
  logic [31:0] rd, rd_cc;
  logic [7:0]  exp_bytes [4];

  apb_xbee_rx #(
    .CLK_HZ        (1000),
    .BAUD          (100),
    .FIFO_DEPTH    (4),
    .TIMEOUT_CYCLES(500)
  ) dut (
    .PCLK     (PCLK),
    .PRESERN  (PRESERN),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR),
    .XBEE_RX  (XBEE_RX),
    .RX_IRQ   (RX_IRQ),
    .link_lost(link_lost)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #2 data = PRDATA;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  // Sends one frame; returns 1 ns after the stop-sample edge (98 edges after the line falls).
  // irq_o is RX_IRQ one cycle before that edge; with rd set, a DATA read access ends on it.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit do_rd,
                            output logic irq_o, output logic [31:0] rd_o);
    @(posedge PCLK); #1;
    XBEE_RX = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) @(posedge PCLK);
      #1 XBEE_RX = b[i];
    end
    repeat (DIV) @(posedge PCLK);
    #1 XBEE_RX = stop;
    rd_o = '0;
    repeat (6) @(posedge PCLK);
    #1;
    if (do_rd) begin
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h0;
    end
    @(posedge PCLK); #1;
    irq_o = RX_IRQ;
    if (do_rd) begin
      PENABLE = 1'b1;
      #2 rd_o = PRDATA;
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic idle(input int n);
    XBEE_RX = 1'b1;
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  initial begin
    PCLK = 1'b0; PRESERN = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; XBEE_RX = 1'b1;
    exp_bytes[0] = 8'h02; exp_bytes[1] = 8'h03; exp_bytes[2] = 8'h04; exp_bytes[3] = 8'h06;

    // Reset state
    #2 PRESERN = 1'b0;
    PADDR = 32'h4;
    repeat (2) @(posedge PCLK);
    #1;
    check("reset_irq", {31'b0, RX_IRQ}, 32'h0);
    check("reset_link_lost", {31'b0, link_lost}, 32'h0);
    check("reset_status", PRDATA, 32'h0);
    check("pready", {31'b0, PREADY}, 32'h1);
    PRESERN = 1'b1;
    idle(5);

    // Empty DATA read does not pop
    apb_read(32'h0, rd);
    check("empty_data", rd, 32'h0000_0100);
    apb_read(32'h4, rd);
    check("empty_status", rd, 32'h0);

    // Single byte, with visibility latency
    send_frame(8'hA5, 1'b1, 1'b0, irq_pre, rd_cc);
    check("a5_irq_before_edge", {31'b0, irq_pre}, 32'h0);
    check("a5_irq_after_edge", {31'b0, RX_IRQ}, 32'h1);
    idle(10);
    apb_read(32'h4, rd);
    check("a5_status", rd, 32'h0000_0101);
    apb_read(32'h0, rd);
    check("a5_data", rd, 32'h0000_00A5);
    apb_read(32'h4, rd);
    check("a5_status_after_pop", rd, 32'h0);
    check("a5_irq_after_pop", {31'b0, RX_IRQ}, 32'h0);
    apb_read(32'h8, rd);
    check("addr2_reads_zero", rd, 32'h0);

    // Overflow with depth 4
    for (int b = 1; b <= 5; b++) begin
      send_frame(8'(b), 1'b1, 1'b0, irq_pre, rd_cc);
      idle(10);
    end
    apb_read(32'h4, rd);
    check("ovf_status", rd, 32'h0000_0407);
    apb_write(32'h4, 32'h4);
    apb_read(32'h4, rd);
    check("ovf_w1c", rd, 32'h0000_0403);

    // Push and pop on the same edge while full
    send_frame(8'h06, 1'b1, 1'b1, irq_pre, rd_cc);
    check("pushpop_data", rd_cc, 32'h0000_0001);
    idle(10);
    apb_read(32'h4, rd);
    check("pushpop_status", rd, 32'h0000_0403);
    for (int i = 0; i < 4; i++) begin
      apb_read(32'h0, rd);
      check($sformatf("drain_%0d", i), rd, {24'b0, exp_bytes[i]});
    end
    apb_read(32'h4, rd);
    check("drain_status", rd, 32'h0);

    // Framing error, then held break must not retrigger
    send_frame(8'h3C, 1'b0, 1'b0, irq_pre, rd_cc);
    apb_read(32'h4, rd);
    check("ferr_status", rd, 32'h0000_0008);
    repeat (50) @(posedge PCLK);
    #1;
    apb_write(32'h4, 32'h8);
    apb_read(32'h4, rd);
    check("ferr_w1c", rd, 32'h0);
    repeat (150) @(posedge PCLK);
    #1;
    apb_read(32'h4, rd);
    check("break_no_retrigger", rd, 32'h0);
    idle(30);
    send_frame(8'h3C, 1'b1, 1'b0, irq_pre, rd_cc);
    idle(10);
    apb_read(32'h4, rd);
    check("ferr_recover_status", rd, 32'h0000_0101);
    apb_read(32'h0, rd);
    check("ferr_recover_data", rd, 32'h0000_003C);

    // Two-cycle glitch: no push, no flag
    @(posedge PCLK); #1;
    XBEE_RX = 1'b0;
    repeat (2) @(posedge PCLK);
    #1 XBEE_RX = 1'b1;
    idle(30);
    apb_read(32'h4, rd);
    check("glitch_status", rd, 32'h0);
    send_frame(8'h5A, 1'b1, 1'b0, irq_pre, rd_cc);
    idle(10);
    apb_read(32'h0, rd);
    check("glitch_recover_data", rd, 32'h0000_005A);

    // Asynchronous reset mid-frame
    send_frame(8'h77, 1'b1, 1'b0, irq_pre, rd_cc);
    idle(10);
    check("pre_reset_irq", {31'b0, RX_IRQ}, 32'h1);
    @(posedge PCLK); #1;
    XBEE_RX = 1'b0;
    repeat (40) @(posedge PCLK);
    #3 PRESERN = 1'b0;
    PADDR = 32'h4;
    #1;
    check("midreset_irq", {31'b0, RX_IRQ}, 32'h0);
    check("midreset_status", PRDATA, 32'h0);
    XBEE_RX = 1'b1;
    repeat (3) @(posedge PCLK);
    #1 PRESERN = 1'b1;
    idle(20);
    send_frame(8'h81, 1'b1, 1'b0, irq_pre, rd_cc);
    idle(10);
    apb_read(32'h4, rd);
    check("postreset_status", rd, 32'h0000_0101);
    apb_read(32'h0, rd);
    check("postreset_data", rd, 32'h0000_0081);

    // Radio silence
    idle(600);
    check("silence_link_lost", {31'b0, link_lost}, {31'b0, TMO_EN});
    apb_read(32'h4, rd);
    check("silence_status", rd, TMO_EN ? 32'h0000_0010 : 32'h0);
    send_frame(8'h55, 1'b1, 1'b0, irq_pre, rd_cc);
    check("link_restored", {31'b0, link_lost}, 32'h0);
    idle(10);
    apb_read(32'h0, rd);
    check("link_data", rd, 32'h0000_0055);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
